// File: rtl/ex_mem_register_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_register_pkg
// Purpose  : Shared definitions for the EX/MEM pipeline register slice:
//            default widths, the hard-wired zero register index and the
//            MEM/WB control bundle layout {RegWrite,MemRead,MemWrite,MemtoReg}.
// Revision : 1.0 - initial release
// ============================================================================
package ex_mem_register_pkg;

    localparam int c_DATA_W_DEF     = 32;
    localparam int c_REG_ADDR_W_DEF = 5;
    localparam int c_CNT_W_DEF      = 32;

    // Register $zero: reads as 0, writes are discarded.
    localparam int c_ZERO_REG       = 0;

    // Control bundle, MSB first: {RegWrite, MemRead, MemWrite, MemtoReg}.
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ctrl_t;

    localparam ctrl_t c_CTRL_NOP = '{reg_write: 1'b0, mem_read: 1'b0,
                                     mem_write: 1'b0, mem_to_reg: 1'b0};

endpackage : ex_mem_register_pkg
`default_nettype wire

// File: rtl/ex_mem_register_fwd_compare.sv
`default_nettype none
// ============================================================================
// Module   : fwd_compare
// Purpose  : One-source forwarding hit detector. Asserts hit when the
//            instruction held in MEM is real, writes a register, that
//            register is not $zero, and it matches the EX-stage source.
// Ports    : valid     in  MEM stage holds a real instruction
//            reg_write in  MEM instruction writes back
//            dst       in  MEM destination register
//            src       in  EX source register under test
//            hit       out forward MEM result to this operand
// Revision : 1.0 - initial release
// ============================================================================
module fwd_compare
    import ex_mem_register_pkg::*;
#(
    parameter int REG_ADDR_W = c_REG_ADDR_W_DEF
) (
    input  logic                  valid,
    input  logic                  reg_write,
    input  logic [REG_ADDR_W-1:0] dst,
    input  logic [REG_ADDR_W-1:0] src,
    output logic                  hit
);

    localparam logic [REG_ADDR_W-1:0] c_ZERO = REG_ADDR_W'(c_ZERO_REG);

    assign hit = valid & reg_write & (dst != c_ZERO) & (dst == src);

endmodule : fwd_compare
`default_nettype wire

// File: rtl/ex_mem_register.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_register
// Purpose  : EX/MEM pipeline register of the 5-stage MIPS core. Captures the
//            ALU result, store data, destination and MEM/WB controls each
//            cycle, with flush (bubble) over stall (hold) over load priority,
//            valid tracking, EX->EX forwarding hit detection, a sticky
//            MemRead&MemWrite conflict flag and a loaded-instruction counter.
// Ports    : clk, reset (async, active-high)
//            Stall, Flush, ExValid              pipeline control
//            ALUresult, ReadData2, WriteReg     EX datapath inputs
//            RegWrite, MemRead, MemWrite, MemtoReg  EX control inputs
//            Rs_E, Rt_E                         live EX source registers
//            *_M outputs                        registered MEM-stage fields
//            ForwardA_M, ForwardB_M             forwarding hits
//            ConflictErr                        sticky conflict flag
//            InstrCount                         valid loads, wrapping
// Revision : 1.0 - initial release
// ============================================================================
module ex_mem_register
    import ex_mem_register_pkg::*;
#(
    parameter int DATA_W     = c_DATA_W_DEF,
    parameter int REG_ADDR_W = c_REG_ADDR_W_DEF,
    parameter int CNT_W      = c_CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic                  ExValid,
    input  logic [DATA_W-1:0]     ALUresult,
    input  logic [DATA_W-1:0]     ReadData2,
    input  logic [REG_ADDR_W-1:0] WriteReg,
    input  logic                  RegWrite,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic                  MemtoReg,
    input  logic [REG_ADDR_W-1:0] Rs_E,
    input  logic [REG_ADDR_W-1:0] Rt_E,
    output logic [DATA_W-1:0]     ALUresult_M,
    output logic [DATA_W-1:0]     WriteData_M,
    output logic [REG_ADDR_W-1:0] WriteReg_M,
    output logic                  RegWrite_M,
    output logic                  MemRead_M,
    output logic                  MemWrite_M,
    output logic                  MemtoReg_M,
    output logic                  Valid_M,
    output logic                  ForwardA_M,
    output logic                  ForwardB_M,
    output logic                  ConflictErr,
    output logic [CNT_W-1:0]      InstrCount
);

    localparam logic [REG_ADDR_W-1:0] c_ZERO = REG_ADDR_W'(c_ZERO_REG);

    logic [DATA_W-1:0]     r_alu;
    logic [DATA_W-1:0]     r_wdata;
    logic [REG_ADDR_W-1:0] r_wreg;
    ctrl_t                 r_ctrl;
    logic                  r_valid;
    logic                  r_conflict;
    logic [CNT_W-1:0]      r_count;

    ctrl_t                 w_ctrl_in;
    logic                  w_conflict_in;

    // Controls of a non-instruction are squashed so a bubble never touches
    // memory or the register file; a write to $zero is dropped here so the
    // forwarding logic and WB stage never see it.
    always_comb begin
        w_ctrl_in            = c_CTRL_NOP;
        if (ExValid) begin
            w_ctrl_in.reg_write  = RegWrite & (WriteReg != c_ZERO);
            w_ctrl_in.mem_read   = MemRead;
            w_ctrl_in.mem_write  = MemWrite;
            w_ctrl_in.mem_to_reg = MemtoReg;
        end
    end

    assign w_conflict_in = ExValid & MemRead & MemWrite;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alu      <= '0;
            r_wdata    <= '0;
            r_wreg     <= '0;
            r_ctrl     <= c_CTRL_NOP;
            r_valid    <= 1'b0;
            r_conflict <= 1'b0;
            r_count    <= '0;
        end else if (Flush) begin
            // Bubble: clear the whole stage; sticky flag and counter persist.
            r_alu   <= '0;
            r_wdata <= '0;
            r_wreg  <= '0;
            r_ctrl  <= c_CTRL_NOP;
            r_valid <= 1'b0;
        end else if (!Stall) begin
            // Data fields are captured regardless of ExValid.
            r_alu   <= ALUresult;
            r_wdata <= ReadData2;
            r_wreg  <= WriteReg;
            r_ctrl  <= w_ctrl_in;
            r_valid <= ExValid;
            if (w_conflict_in) begin
                r_conflict <= 1'b1;
            end
            if (ExValid) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    // Forwarding looks at the live EX sources every cycle, stalled or not.
    fwd_compare #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .valid     (r_valid),
        .reg_write (r_ctrl.reg_write),
        .dst       (r_wreg),
        .src       (Rs_E),
        .hit       (ForwardA_M)
    );

    fwd_compare #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .valid     (r_valid),
        .reg_write (r_ctrl.reg_write),
        .dst       (r_wreg),
        .src       (Rt_E),
        .hit       (ForwardB_M)
    );

    assign ALUresult_M = r_alu;
    assign WriteData_M = r_wdata;
    assign WriteReg_M  = r_wreg;
    assign RegWrite_M  = r_ctrl.reg_write;
    assign MemRead_M   = r_ctrl.mem_read;
    assign MemWrite_M  = r_ctrl.mem_write;
    assign MemtoReg_M  = r_ctrl.mem_to_reg;
    assign Valid_M     = r_valid;
    assign ConflictErr = r_conflict;
    assign InstrCount  = r_count;

endmodule : ex_mem_register
`default_nettype wire

// File: tb/tb_ex_mem_register.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_register
// Purpose  : Self-checking bench for ex_mem_register (CNT_W = 4). Directed
//            scenarios followed by randomized traffic, all compared against
//            a behavioural model of the MEM-stage contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mem_register;

    localparam int c_DW  = 32;
    localparam int c_AW  = 5;
    localparam int c_CW  = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            Stall, Flush, ExValid;
    logic [c_DW-1:0] ALUresult, ReadData2;
    logic [c_AW-1:0] WriteReg, Rs_E, Rt_E;
    logic            RegWrite, MemRead, MemWrite, MemtoReg;
    logic [c_DW-1:0] ALUresult_M, WriteData_M;
    logic [c_AW-1:0] WriteReg_M;
    logic            RegWrite_M, MemRead_M, MemWrite_M, MemtoReg_M;
    logic            Valid_M, ForwardA_M, ForwardB_M, ConflictErr;
    logic [c_CW-1:0] InstrCount;

    int errors = 0;
    int checks = 0;

    // Behavioural model: what instruction the MEM stage holds.
    int unsigned m_alu, m_wd, m_wr, m_cnt;
    bit          m_valid, m_rw, m_mr, m_mw, m_m2r, m_err;

    ex_mem_register #(.DATA_W(c_DW), .REG_ADDR_W(c_AW), .CNT_W(c_CW)) dut (
        .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush),
        .ExValid(ExValid), .ALUresult(ALUresult), .ReadData2(ReadData2),
        .WriteReg(WriteReg), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .Rs_E(Rs_E), .Rt_E(Rt_E),
        .ALUresult_M(ALUresult_M), .WriteData_M(WriteData_M),
        .WriteReg_M(WriteReg_M), .RegWrite_M(RegWrite_M),
        .MemRead_M(MemRead_M), .MemWrite_M(MemWrite_M),
        .MemtoReg_M(MemtoReg_M), .Valid_M(Valid_M),
        .ForwardA_M(ForwardA_M), .ForwardB_M(ForwardB_M),
        .ConflictErr(ConflictErr), .InstrCount(InstrCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_alu = 0; m_wd = 0; m_wr = 0; m_cnt = 0;
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0; m_err = 0;
    endtask

    // Forwarding is wanted when MEM will write a real, nonzero register
    // that EX wants to read.
    function automatic bit want_fwd(input int unsigned src);
        return m_valid && m_rw && (m_wr != 0) && (m_wr == src);
    endfunction

    task automatic model_edge();
        if (Flush) begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0;
            m_alu = 0; m_wd = 0; m_wr = 0;
        end else if (!Stall) begin
            m_valid = ExValid;
            m_alu   = ALUresult;
            m_wd    = ReadData2;
            m_wr    = WriteReg;
            m_rw    = ExValid && RegWrite && (WriteReg != 0);
            m_mr    = ExValid && MemRead;
            m_mw    = ExValid && MemWrite;
            m_m2r   = ExValid && MemtoReg;
            if (ExValid && MemRead && MemWrite) m_err = 1;
            if (ExValid) m_cnt = (m_cnt + 1) % (1 << c_CW);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".alu"},   ALUresult_M, m_alu);
        check({tag, ".wd"},    WriteData_M, m_wd);
        check({tag, ".wr"},    32'(WriteReg_M), m_wr);
        check({tag, ".rw"},    32'(RegWrite_M), 32'(m_rw));
        check({tag, ".mr"},    32'(MemRead_M), 32'(m_mr));
        check({tag, ".mw"},    32'(MemWrite_M), 32'(m_mw));
        check({tag, ".m2r"},   32'(MemtoReg_M), 32'(m_m2r));
        check({tag, ".valid"}, 32'(Valid_M), 32'(m_valid));
        check({tag, ".fwda"},  32'(ForwardA_M), 32'(want_fwd(Rs_E)));
        check({tag, ".fwdb"},  32'(ForwardB_M), 32'(want_fwd(Rt_E)));
        check({tag, ".err"},   32'(ConflictErr), 32'(m_err));
        check({tag, ".cnt"},   32'(InstrCount), m_cnt);
    endtask

    // One clock edge: model sees the same inputs as the DUT, outputs are
    // sampled 1 ns after the edge; inputs change only after that.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_in(input bit v, input int unsigned alu,
                          input int unsigned wr, input bit rw,
                          input bit mr, input bit mw);
        ExValid = v; ALUresult = alu; ReadData2 = alu ^ 32'hA5A5_0000;
        WriteReg = c_AW'(wr); RegWrite = rw; MemRead = mr; MemWrite = mw;
        MemtoReg = mr;
    endtask

    task automatic randomize_in();
        ExValid   = ($urandom_range(0, 3) != 0);
        ALUresult = $urandom;
        ReadData2 = $urandom;
        WriteReg  = ($urandom_range(0, 5) == 0) ? '0 : c_AW'($urandom_range(0, 31));
        RegWrite  = $urandom_range(0, 1);
        MemRead   = ($urandom_range(0, 3) == 0);
        MemWrite  = ($urandom_range(0, 3) == 0);
        MemtoReg  = $urandom_range(0, 1);
        Rs_E      = c_AW'($urandom_range(0, 31));
        Rt_E      = c_AW'($urandom_range(0, 31));
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        #3 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; Stall = 0; Flush = 0; Rs_E = 0; Rt_E = 0;
        set_in(0, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk); #1;
        check_all("reset_init");
        reset = 1'b0;

        // 2: basic load and forwarding hit/miss
        set_in(1, 32'h0000_0010, 8, 1, 0, 0);
        step();
        check("load.alu", ALUresult_M, 32'h10);
        check("load.valid", 32'(Valid_M), 1);
        check("load.cnt", 32'(InstrCount), 1);
        Rs_E = 8; #1;
        check("fwda.hit", 32'(ForwardA_M), 1);
        Rs_E = 9; #1;
        check("fwda.miss", 32'(ForwardA_M), 0);
        Rt_E = 8; #1;
        check_all("fwd");

        // 3: stall for three edges while inputs move, then flush+stall
        Stall = 1;
        for (int i = 0; i < 3; i++) begin
            randomize_in();
            step();
            check_all("stall");
        end
        check("stall.cnt", 32'(InstrCount), 1);
        check("stall.alu", ALUresult_M, 32'h10);
        Flush = 1;
        step();
        check("flush.valid", 32'(Valid_M), 0);
        check("flush.rw", 32'(RegWrite_M), 0);
        check("flush.cnt", 32'(InstrCount), 1);
        check_all("flush");
        Flush = 0; Stall = 0;

        // 1: asynchronous reset while MEM holds a valid instruction
        set_in(1, 32'h1234, 3, 1, 0, 0);
        step();
        check("pre_rst.valid", 32'(Valid_M), 1);
        do_reset();
        // release happened away from an edge; next edge is a normal load
        set_in(1, 32'h0000_0044, 6, 1, 0, 0);
        step();
        check("post_rst.cnt", 32'(InstrCount), 1);
        check_all("post_rst");
        #2 reset = 1'b1; #1;
        check("async_rst.valid", 32'(Valid_M), 0);
        check("async_rst.alu", ALUresult_M, 0);
        check("async_rst.cnt", 32'(InstrCount), 0);
        model_reset();
        check_all("async_rst");
        reset = 1'b0;

        // 4: write to $zero is suppressed
        set_in(1, 32'h55, 0, 1, 0, 0);
        Rs_E = 0; Rt_E = 0;
        step();
        check("zero.rw", 32'(RegWrite_M), 0);
        check("zero.fwdb", 32'(ForwardB_M), 0);
        check_all("zero");

        // 5: MemRead&MemWrite conflict is sticky
        set_in(1, 32'h80, 4, 0, 1, 1);
        step();
        check("conf.set", 32'(ConflictErr), 1);
        check_all("conf");
        for (int i = 0; i < 5; i++) begin
            set_in(1, 32'h100 + i, 5 + i, 1, 0, 0);
            step();
            check_all("conf_hold");
        end
        check("conf.sticky", 32'(ConflictErr), 1);
        do_reset();
        check("conf.clr", 32'(ConflictErr), 0);

        // 6: counter wrap at 2^CNT_W
        for (int i = 0; i < 15; i++) begin
            set_in(1, i, 1 + i, 1, 0, 0);
            step();
        end
        check("wrap.pre", 32'(InstrCount), 15);
        set_in(1, 32'hFF, 2, 1, 0, 0);
        step();
        check("wrap.zero", 32'(InstrCount), 0);
        check_all("wrap");

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            randomize_in();
            Stall = ($urandom_range(0, 3) == 0);
            Flush = ($urandom_range(0, 9) == 0);
            step();
            check_all("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ex_mem_register
`default_nettype wire
